// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: parametrised pipeline stage register with a 2-entry skid
// buffer. The main entry M drives the outputs and the skid entry S absorbs one
// overflow beat, so in_ready_o can be a flop. stall_i holds the head entry,
// flush_i squashes everything, and a saturating counter tracks stalled cycles.
module pipe_stage_skid #(
  parameter int DATA_W    = 32,
  parameter int NUM_LANES = 4,
  parameter int CTRL_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [NUM_LANES*DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0]           in_ctrl_i,
  input  logic                        stall_i,
  input  logic                        flush_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [NUM_LANES*DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0]           out_ctrl_o,
  output logic [1:0]                  occupancy_o,
  output logic [CNT_W-1:0]            stall_cnt_o
);

  localparam int PAY_W = NUM_LANES * DATA_W;

  // Encoding equals the number of held entries, so occupancy_o is the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PAY_W-1:0]   m_data_q, m_data_d;
  logic [CTRL_W-1:0]  m_ctrl_q, m_ctrl_d;
  logic [PAY_W-1:0]   s_data_q, s_data_d;
  logic [CTRL_W-1:0]  s_ctrl_q, s_ctrl_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               out_valid_s;
  logic               acc_s;
  logic               pop_s;

  // Handshake qualifiers derived from the registered state.
  always_comb begin
    out_valid_s = (state_q != ST_EMPTY);
    acc_s       = in_valid_i & in_ready_q;
    pop_s       = out_valid_s & out_ready_i & ~stall_i;
  end

  // State and storage registers; reset drops every entry immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      m_data_q    <= '0;
      m_ctrl_q    <= '0;
      s_data_q    <= '0;
      s_ctrl_q    <= '0;
      in_ready_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_data_q    <= m_data_d;
      m_ctrl_q    <= m_ctrl_d;
      s_data_q    <= s_data_d;
      s_ctrl_q    <= s_ctrl_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state and datapath load selection; flush overrides every other event.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc_s) begin
            state_d  = ST_ONE;
            m_data_d = in_data_i;
            m_ctrl_d = in_ctrl_i;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (acc_s && pop_s) begin
            state_d  = ST_ONE;
            m_data_d = in_data_i;
            m_ctrl_d = in_ctrl_i;
          end else if (acc_s) begin
            state_d  = ST_FULL;
            s_data_d = in_data_i;
            s_ctrl_d = in_ctrl_i;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready_q is low here, so no accept can coincide with this state.
          if (pop_s) begin
            state_d  = ST_ONE;
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Registered ready looks at the next state so it never over-accepts.
  always_comb begin
    if (state_d == ST_FULL) begin
      in_ready_d = 1'b0;
    end else begin
      in_ready_d = 1'b1;
    end
  end

  // Saturating count of cycles where a valid head entry is held by stall_i.
  always_comb begin
    if (out_valid_s && stall_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Output decode; control is gated to zero on bubbles so no write enable leaks.
  always_comb begin
    out_valid_o = out_valid_s;
    in_ready_o  = in_ready_q;
    out_data_o  = m_data_q;
    occupancy_o = state_q;
    stall_cnt_o = stall_cnt_q;
    if (out_valid_s) begin
      out_ctrl_o = m_ctrl_q;
    end else begin
      out_ctrl_o = '0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed testbench for pipe_stage_skid: single beat, backpressure, stall,
// flush, full-rate streaming, asynchronous reset and counter saturation.
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, stall, flush, out_valid, out_ready;
  logic [127:0] in_data, out_data;
  logic [7:0]   in_ctrl, out_ctrl;
  logic [1:0]   occ;
  logic [15:0]  scnt;

  // Second instance with a 2-bit stall counter for the saturation check.
  logic         b_in_valid, b_in_ready, b_stall, b_out_valid;
  logic [127:0] b_out_data;
  logic [7:0]   b_out_ctrl;
  logic [1:0]   b_occ;
  logic [1:0]   b_scnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl),
    .stall_i(stall), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_ctrl_o(out_ctrl),
    .occupancy_o(occ), .stall_cnt_o(scnt)
  );

  pipe_stage_skid #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .in_data_i(128'h0), .in_ctrl_i(8'h81),
    .stall_i(b_stall), .flush_i(1'b0),
    .out_valid_o(b_out_valid), .out_ready_i(1'b1),
    .out_data_o(b_out_data), .out_ctrl_o(b_out_ctrl),
    .occupancy_o(b_occ), .stall_cnt_o(b_scnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pay(input logic [7:0] b);
    pay = {32'hD000_0000 | {24'h0, b}, 32'hC000_0000 | {24'h0, b},
           32'hB000_0000 | {24'h0, b}, 32'hA000_0000 | {24'h0, b}};
  endfunction

  function automatic logic [7:0] ctl(input logic [7:0] b);
    ctl = {1'b1, b[6:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [7:0] b);
    in_valid = v;
    in_data  = pay(b);
    in_ctrl  = ctl(b);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 128'h0; in_ctrl = 8'h00;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_stall = 1'b0;
    #2;
    check("rst_valid", 128'(out_valid), 128'(1'b0));
    check("rst_ready", 128'(in_ready), 128'(1'b0));
    check("rst_data", out_data, 128'h0);
    check("rst_ctrl", 128'(out_ctrl), 128'(8'h00));
    check("rst_occ", 128'(occ), 128'(2'd0));
    check("rst_cnt", 128'(scnt), 128'(16'd0));
    tick(); tick();
    rst = 1'b0;
    check("ready_low_after_rel", 128'(in_ready), 128'(1'b0));
    tick();
    check("ready_rises", 128'(in_ready), 128'(1'b1));

    // T1 single beat
    in_valid = 1'b1; in_data = {4{32'h1122_3344}}; in_ctrl = 8'h0F; out_ready = 1'b1;
    check("t1_pre_ctrl_gated", 128'(out_ctrl), 128'(8'h00));
    tick();
    in_valid = 1'b0;
    check("t1_valid", 128'(out_valid), 128'(1'b1));
    check("t1_data", out_data, {4{32'h1122_3344}});
    check("t1_ctrl", 128'(out_ctrl), 128'(8'h0F));
    check("t1_occ", 128'(occ), 128'(2'd1));
    tick();
    check("t1_drain_valid", 128'(out_valid), 128'(1'b0));
    check("t1_drain_ctrl", 128'(out_ctrl), 128'(8'h00));

    // T2 backpressure A,B,C
    out_ready = 1'b0;
    send(1'b1, 8'h0A); tick();
    check("t2_occ1", 128'(occ), 128'(2'd1));
    check("t2_ready1", 128'(in_ready), 128'(1'b1));
    send(1'b1, 8'h0B); tick();
    check("t2_occ2", 128'(occ), 128'(2'd2));
    check("t2_ready_drop", 128'(in_ready), 128'(1'b0));
    check("t2_head_a", out_data, pay(8'h0A));
    send(1'b1, 8'h0C); tick();
    check("t2_hold_occ", 128'(occ), 128'(2'd2));
    check("t2_hold_a", out_data, pay(8'h0A));
    check("t2_hold_ctrl", 128'(out_ctrl), 128'(ctl(8'h0A)));
    out_ready = 1'b1; tick();
    check("t2_b_data", out_data, pay(8'h0B));
    check("t2_b_ctrl", 128'(out_ctrl), 128'(ctl(8'h0B)));
    check("t2_b_occ", 128'(occ), 128'(2'd1));
    check("t2_b_ready", 128'(in_ready), 128'(1'b1));
    tick();
    in_valid = 1'b0;
    check("t2_c_data", out_data, pay(8'h0C));
    check("t2_c_occ", 128'(occ), 128'(2'd1));
    tick();
    check("t2_empty", 128'(occ), 128'(2'd0));

    // T3 stall holds D for five cycles
    send(1'b1, 8'h0D); tick();
    in_valid = 1'b0; stall = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t3_d_stable", out_data, pay(8'h0D));
      check("t3_occ", 128'(occ), 128'(2'd1));
      check("t3_cnt", 128'(scnt), 128'(k));
    end
    stall = 1'b0; tick();
    check("t3_popped", 128'(occ), 128'(2'd0));
    check("t3_cnt_kept", 128'(scnt), 128'(16'd5));

    // T4 flush with occupancy 2 and a same-cycle entry E
    out_ready = 1'b0;
    send(1'b1, 8'h21); tick();
    send(1'b1, 8'h22); tick();
    check("t4_full", 128'(occ), 128'(2'd2));
    send(1'b1, 8'h0E); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_occ", 128'(occ), 128'(2'd0));
    check("t4_valid", 128'(out_valid), 128'(1'b0));
    check("t4_ctrl", 128'(out_ctrl), 128'(8'h00));
    check("t4_ready", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b1; tick();
    check("t4_no_e", 128'(out_valid), 128'(1'b0));
    check("t4_cnt_kept", 128'(scnt), 128'(16'd5));

    // T5 full-rate streaming of 100 distinct entries
    for (int i = 0; i < 100; i++) begin
      send(1'b1, 8'(i + 64));
      tick();
      check("t5_data", out_data, pay(8'(i + 64)));
      check("t5_occ", 128'(occ), 128'(2'd1));
      check("t5_ready", 128'(in_ready), 128'(1'b1));
    end
    in_valid = 1'b0; tick();
    check("t5_drain", 128'(occ), 128'(2'd0));

    // T6 asynchronous reset between edges while FULL
    out_ready = 1'b0;
    send(1'b1, 8'h31); tick();
    send(1'b1, 8'h32); tick();
    in_valid = 1'b0;
    check("t6_full", 128'(occ), 128'(2'd2));
    #2; rst = 1'b1; #1;
    check("t6_valid", 128'(out_valid), 128'(1'b0));
    check("t6_ready", 128'(in_ready), 128'(1'b0));
    check("t6_occ", 128'(occ), 128'(2'd0));
    check("t6_data", out_data, 128'h0);
    check("t6_ctrl", 128'(out_ctrl), 128'(8'h00));
    check("t6_cnt", 128'(scnt), 128'(16'd0));
    tick();
    rst = 1'b0; tick();
    check("t6_ready_back", 128'(in_ready), 128'(1'b1));

    // CNT_W=2 instance: counter saturates at 3
    b_in_valid = 1'b1; tick();
    b_in_valid = 1'b0; b_stall = 1'b1;
    check("sat_valid", 128'(b_out_valid), 128'(1'b1));
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("sat_cnt", 128'(b_scnt), 128'((k > 3) ? 3 : k));
    end
    b_stall = 1'b0; tick();
    check("sat_pop", 128'(b_occ), 128'(2'd0));
    check("sat_cnt_kept", 128'(b_scnt), 128'(2'd3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
